// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: byte-wide program memory reads (2 per instruction), DEPTH-entry instruction/PC buffer.
// Optional FQ_MISALIGN_TRAP_EN: an odd redirect target traps (sticky misalign) and halts fetch until an even redirect.
module instr_fetch_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [7:0]             mem_addr,
  input  logic [7:0]             mem_rdata,
  input  logic                   redirect,
  input  logic [7:0]             redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_instr,
  output logic [7:0]             out_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // state  | meaning
  // S_HI   | idle / waiting for room; issues the hi-byte read when the queue has space
  // S_LO   | hi byte returning; issues the lo-byte read
  // S_PUSH | lo byte returning; pushes the instruction and may chain the next hi read
  typedef enum logic [1:0] {S_HI, S_LO, S_PUSH} state_t;

  state_t         r_state;
  logic [7:0]     r_fetch_pc;
  logic [7:0]     r_hi;
  logic [15:0]    r_instr [DEPTH];
  logic [7:0]     r_pc    [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_mem_req;
  logic [7:0]     r_mem_addr;
  logic           r_misalign;

  logic           w_pop;
  logic           w_push;
  logic           w_halt;
  logic           w_odd_trap;
  logic [7:0]     w_pc_next;
  logic [7:0]     w_redirect_pc;
  logic [CW-1:0]  w_cnt_after;

  assign w_pop         = out_valid & out_ready;
  assign w_push        = (r_state == S_PUSH);
  assign w_pc_next     = r_fetch_pc + 8'd2;
  assign w_redirect_pc = redirect_pc & 8'hFE;
  assign w_cnt_after   = r_count + CW'(1) - CW'(w_pop);

`ifdef FQ_MISALIGN_TRAP_EN
  assign w_halt     = r_misalign;
  assign w_odd_trap = redirect_pc[0];
`else
  assign w_halt     = 1'b0;
  assign w_odd_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_HI;
      r_fetch_pc <= RESET_PC;
      r_hi       <= 8'h00;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 8'h00;
      r_misalign <= 1'b0;
    end else if (redirect) begin
      // Flush wins over everything; a concurrent pop is simply absorbed by the clear.
      r_state    <= S_HI;
      r_fetch_pc <= w_redirect_pc;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_mem_req  <= 1'b0;
      r_misalign <= w_odd_trap;
    end else begin
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      case (r_state)
        S_HI: begin
          if (!w_halt && (r_count < FULL)) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
            r_state    <= S_LO;
          end else begin
            r_mem_req  <= 1'b0;
          end
        end
        S_LO: begin
          r_hi       <= mem_rdata;
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_fetch_pc + 8'd1;
          r_state    <= S_PUSH;
        end
        S_PUSH: begin
          r_wptr     <= r_wptr + AW'(1);
          r_fetch_pc <= w_pc_next;
          // Chain the next hi read only if the slot will still exist after this push/pop.
          if (w_cnt_after < FULL) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_pc_next;
            r_state    <= S_LO;
          end else begin
            r_mem_req  <= 1'b0;
            r_state    <= S_HI;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_HI;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !redirect && w_push) begin
      r_instr[r_wptr] <= {r_hi, mem_rdata};
      r_pc[r_wptr]    <= r_fetch_pc;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign count     = r_count;
  assign misalign  = r_misalign;
  assign out_valid = (r_count != '0);
  assign out_instr = out_valid ? r_instr[r_rptr] : 16'h0000;
  assign out_pc    = out_valid ? r_pc[r_rptr]    : 8'h00;

endmodule
